instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 18 +
 rtl/instruction_fetch_pc_next_calc.sv | 46 ++++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU package: fetch FSM states and instruction field widths.
// Imported by the fetch stage and its next-PC helper.
package instruction_fetch_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 6;
  localparam int JFIELD_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [JFIELD_W-1:0] jfield_t;

endpackage

// File: rtl/instruction_fetch_pc_next_calc.sv
// Next-PC mux and redirect target adders (jump > branch > sequential).
// In: pc, instr_pc, instr_valid, jump/branch controls. Out: next_pc, redirect.
module pc_next_calc
  import instruction_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            instr_valid,
  input  logic            jump,
  input  jfield_t         jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect
);

  logic [XLEN-1:0] link;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] b_tgt;
  logic            do_jump;
  logic            do_br;

  assign link    = instr_pc + 32'd4;
  assign j_tgt   = {link[31:28], jump_target, 2'b00};
  assign b_tgt   = link + (branch_offset << 2);
  // Controls only apply to a live instruction
  assign do_jump = instr_valid & jump;
  assign do_br   = instr_valid & branch_taken & ~jump;

  always_comb begin
    next_pc  = pc + 32'd4;
    redirect = 1'b0;
    unique case (1'b1)
      do_jump: begin
        next_pc  = j_tgt & ~32'h3;
        redirect = 1'b1;
      end
      do_br: begin
        next_pc  = b_tgt & ~32'h3;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: IDLE/RUN/HALT FSM, PC, instruction register, retire count.
// Drives the ROM address/strobe and hands instr/instr_pc/instr_valid to decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0]     RESET_PC    = 32'h0000_0000,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            jump,
  input  jfield_t         jump_target,
  output logic [XLEN-1:0] rom_address,
  output logic            rom_read_enable,
  input  logic [XLEN-1:0] rom_data,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            halted,
  output logic [XLEN-1:0] retired_count
);

  fetch_state_t    state;
  fetch_state_t    state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            halt_go;
  logic            advance;

  pc_next_calc u_next (
    .pc            (pc),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  assign advance = (state == RUN) & ~stall;
  assign halt_go = advance & instr_valid &
                   (instr[31:26] == HALT_OPCODE);

  always_comb begin
    state_n         = state;
    rom_read_enable = 1'b0;
    halted          = 1'b0;
    unique case (state)
      IDLE: state_n = RUN;
      RUN: begin
        rom_read_enable = 1'b1;
        if (halt_go) state_n = HALT;
      end
      HALT: halted = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  assign rom_address = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      instr         <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      retired_count <= '0;
    end else begin
      state <= state_n;
      if (advance) begin
        if (instr_valid) retired_count <= retired_count + 32'd1;
        if (halt_go) begin
          // Halt word stays in instr; PC freezes on the word after it
          instr_valid <= 1'b0;
        end else if (redirect) begin
          // Word fetched this cycle is on the wrong path
          instr_valid <= 1'b0;
          pc          <= next_pc;
        end else begin
          instr       <= rom_data;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= next_pc;
        end
      end else if (state == HALT) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table, halt/reset sequences,
// and randomized traffic against a behavioural fetch model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] rom_address;
  logic        rom_read_enable;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [31:0] retired_count;

  logic [31:0] mem [64];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = mem[rom_address[7:2]];

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .jump_target     (jump_target),
    .rom_address     (rom_address),
    .rom_read_enable (rom_read_enable),
    .rom_data        (rom_data),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .retired_count   (retired_count)
  );

  function automatic logic [31:0] dword(int i);
    return {6'b000001, 18'h0, 8'(i)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_target   = '0;
  endtask

  // Reset, check cleared outputs, release at a falling edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pc", rom_address, 32'h0);
    chk("rst_en", {31'b0, rom_read_enable}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_cnt", retired_count, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        bt;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[14];

  // Behavioural model state
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  logic        m_valid;

  task automatic model_step();
    logic [31:0] link;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 && !stall) begin
      if (m_valid) m_cnt = m_cnt + 1;
      link = m_ipc + 4;
      if (m_valid && m_instr[31:26] == 6'h3f) begin
        m_phase = 2;
        m_valid = 0;
      end else if (m_valid && jump) begin
        m_pc    = {link[31:28], jump_target, 2'b00};
        m_valid = 0;
      end else if (m_valid && branch_taken) begin
        m_pc    = link + branch_offset * 4;
        m_valid = 0;
      end else begin
        m_instr = mem[m_pc[7:2]];
        m_ipc   = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 4;
      end
    end
  endtask

  initial begin
    int    k;
    logic [31:0] hpc, hinstr;
    for (int i = 0; i < 64; i++) mem[i] = dword(i);

    tbl[0]  = '{0, 0, 32'd0, 0, 26'h0, 32'h4,  1, 32'h0,  32'd0};
    tbl[1]  = '{0, 0, 32'd0, 0, 26'h0, 32'h8,  1, 32'h4,  32'd1};
    tbl[2]  = '{0, 0, 32'd0, 0, 26'h0, 32'hC,  1, 32'h8,  32'd2};
    tbl[3]  = '{0, 1, -32'sd3, 0, 26'h0, 32'h0, 0, 32'h0, 32'd3};
    tbl[4]  = '{0, 0, 32'd0, 0, 26'h0, 32'h4,  1, 32'h0,  32'd3};
    tbl[5]  = '{0, 0, 32'd0, 0, 26'h0, 32'h8,  1, 32'h4,  32'd4};
    tbl[6]  = '{0, 0, 32'd0, 1, 26'h10, 32'h40, 0, 32'h0, 32'd5};
    tbl[7]  = '{0, 0, 32'd0, 0, 26'h0, 32'h44, 1, 32'h40, 32'd5};
    tbl[8]  = '{0, 0, 32'd0, 1, 26'h10, 32'h40, 0, 32'h0, 32'd6};
    tbl[9]  = '{0, 1, 32'd5, 0, 26'h0, 32'h44, 1, 32'h40, 32'd6};
    tbl[10] = '{1, 1, 32'd5, 1, 26'h3, 32'h44, 1, 32'h40, 32'd6};
    tbl[11] = '{1, 1, 32'd5, 1, 26'h3, 32'h44, 1, 32'h40, 32'd6};
    tbl[12] = '{1, 1, 32'd5, 1, 26'h3, 32'h44, 1, 32'h40, 32'd6};
    tbl[13] = '{0, 0, 32'd0, 0, 26'h0, 32'h48, 1, 32'h44, 32'd7};

    // Directed stream: sequential, branch, jump, stall
    do_reset();
    @(negedge clk);
    chk("idle_en", {31'b0, rom_read_enable}, 32'h1);
    chk("first_addr", rom_address, 32'h0);
    for (int i = 0; i < 14; i++) begin
      stall         = tbl[i].stall;
      branch_taken  = tbl[i].bt;
      branch_offset = tbl[i].off;
      jump          = tbl[i].jmp;
      jump_target   = tbl[i].jt;
      @(negedge clk);
      chk($sformatf("t%0d_pc", i), rom_address, tbl[i].e_pc);
      chk($sformatf("t%0d_valid", i), {31'b0, instr_valid},
          {31'b0, tbl[i].e_valid});
      chk($sformatf("t%0d_cnt", i), retired_count, tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_ipc", i), instr_pc, tbl[i].e_ipc);
        chk($sformatf("t%0d_instr", i), instr,
            dword(int'(tbl[i].e_ipc[7:2])));
      end
    end
    idle_inputs();

    // Halt word at 0xC
    mem[3] = 32'hFC00_0000;
    do_reset();
    k = 0;
    while (!halted && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("halt_reached", {31'b0, halted}, 32'h1);
    chk("halt_cnt", retired_count, 32'd4);
    chk("halt_en", {31'b0, rom_read_enable}, 32'h0);
    chk("halt_valid", {31'b0, instr_valid}, 32'h0);
    hpc    = rom_address;
    hinstr = instr;
    jump   = 1'b1;
    branch_taken = 1'b1;
    repeat (10) @(negedge clk);
    chk("halt_hold", {31'b0, halted}, 32'h1);
    chk("halt_pc_hold", rom_address, hpc);
    chk("halt_instr_hold", instr, hinstr);
    chk("halt_cnt_hold", retired_count, 32'd4);
    chk("halt_en_hold", {31'b0, rom_read_enable}, 32'h0);
    mem[3] = dword(3);

    // Asynchronous reset mid-run at PC 0x20
    do_reset();
    k = 0;
    while (rom_address != 32'h20 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("reach_0x20", rom_address, 32'h20);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", rom_address, 32'h0);
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_en", {31'b0, rom_read_enable}, 32'h0);
    chk("arst_cnt", retired_count, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_ipc", instr_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_en", {31'b0, rom_read_enable}, 32'h1);
    chk("restart_addr", rom_address, 32'h0);
    @(negedge clk);
    chk("restart_ipc", instr_pc, 32'h0);
    chk("restart_valid", {31'b0, instr_valid}, 32'h1);

    // Randomized traffic against the model
    do_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_instr = '0;
    m_ipc   = '0;
    m_cnt   = '0;
    m_valid = 0;
    for (int c = 0; c < 600; c++) begin
      chk("r_pc", rom_address, m_pc);
      chk("r_en", {31'b0, rom_read_enable}, {31'b0, m_phase == 1});
      chk("r_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("r_halted", {31'b0, halted}, {31'b0, m_phase == 2});
      chk("r_cnt", retired_count, m_cnt);
      if (m_valid) begin
        chk("r_ipc", instr_pc, m_ipc);
        chk("r_instr", instr, m_instr);
      end
      stall         = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 15);
      jump          = ($urandom_range(0, 99) < 10);
      branch_offset = ($urandom_range(0, 3) == 0) ? $urandom
                      : 32'($urandom_range(0, 16)) - 32'd8;
      jump_target   = 26'($urandom);
      model_step();
      @(negedge clk);
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
